mmul_host: RTL and testbench

Initiator-side controller for the `mmul` 3×3 matrix unit. It assembles two packed operand matrices from an inbound byte stream and drives `mat_a`, `mat_b` and `enable` into `mmul`. It waits for `done`, captures the packed result and returns it as an outbound byte stream. It sits between a byte-wide host/link interface and the `mmul` instance.

---
 rtl/mmul_host.sv | 237 +++++++++++++++++++++++
 tb/tb_mmul_host.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmul_host.sv
// mmul_host: initiator-side controller for the mmul 3x3 matrix unit.
//
// Purpose:
//   Collects 2*DIM*DIM operand bytes from an inbound byte stream into
//   packed matrices mat_a and mat_b. It then raises enable towards mmul
//   and waits for done. The packed result is captured and returned as an
//   outbound byte stream, element 0 first.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_data    inbound operand byte        in_valid / in_ready handshake
//   out_data   outbound result byte        out_valid / out_ready handshake
//   mat_a      packed operand A; element k = i*DIM+j at [k*ELEM_W +: ELEM_W]
//   mat_b      packed operand B, same packing
//   enable     start/hold request to mmul
//   mat_result packed result from mmul
//   done       mmul result valid
//   busy       low only in LOAD with no byte yet accepted
//   err        sticky run-timeout flag (tied 0 unless the watchdog is built)
//
// Build option:
//   MMUL_HOST_TIMEOUT_EN  when defined, adds a RUN watchdog of TIMEOUT_CYCLES
//                         cycles that aborts to DRAIN and raises err.
//   TIMEOUT_CYCLES is only meaningful in that build.
module mmul_host #(
  parameter int ELEM_W         = 8,
  parameter int DIM            = 3,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int MAT_W         = DIM * DIM * ELEM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAT_W-1:0]  mat_a,
  output logic [MAT_W-1:0]  mat_b,
  output logic              enable,
  input  logic [MAT_W-1:0]  mat_result,
  input  logic              done,
  output logic              busy,
  output logic              err
);

  localparam int NELEM = DIM * DIM;
  localparam int CNT_W = $clog2(2 * NELEM + 1);

  localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(2 * NELEM - 1);
  localparam logic [CNT_W-1:0] LAST_OUT = CNT_W'(NELEM - 1);
  localparam logic [CNT_W-1:0] B_BASE   = CNT_W'(NELEM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_SEND,
    S_DRAIN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ELEM_W-1:0]  out_data_q, out_data_d;
  logic [MAT_W-1:0]   mat_a_q, mat_a_d;
  logic [MAT_W-1:0]   mat_b_q, mat_b_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  // Remaining (not yet presented) result elements, element 1 at the bottom.
  logic [MAT_W-1:0]   res_q, res_d;

`ifdef MMUL_HOST_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic               err_q, err_d;
  logic [15:0]        tmo_q, tmo_d;
`endif

  logic               in_fire;
  logic               out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mat_a_d     = mat_a_q;
    mat_b_d     = mat_b_q;
    enable_d    = enable_q;
    res_d       = res_q;
`ifdef MMUL_HOST_TIMEOUT_EN
    err_d       = err_q;
    tmo_d       = tmo_q;
`endif

    case (state_q)
      // One idle cycle after reset; in_ready comes up on the first LOAD edge.
      S_IDLE: begin
        in_ready_d = 1'b0;
        state_d    = S_LOAD;
      end

      S_LOAD: begin
        in_ready_d = 1'b1;
        if (in_fire) begin
          if (cnt_q < B_BASE) begin
            mat_a_d[int'(cnt_q) * ELEM_W +: ELEM_W] = in_data;
          end else begin
            mat_b_d[int'(cnt_q - B_BASE) * ELEM_W +: ELEM_W] = in_data;
          end
`ifdef MMUL_HOST_TIMEOUT_EN
          if (cnt_q == '0) begin
            err_d = 1'b0;
          end
`endif
          if (cnt_q == LAST_IN) begin
            // Start mmul on the same edge that takes the last operand byte.
            in_ready_d = 1'b0;
            enable_d   = 1'b1;
            cnt_d      = '0;
            state_d    = S_RUN;
`ifdef MMUL_HOST_TIMEOUT_EN
            tmo_d      = '0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_RUN: begin
        enable_d = 1'b1;
        if (done) begin
          enable_d    = 1'b0;
          out_valid_d = 1'b1;
          out_data_d  = mat_result[ELEM_W-1:0];
          res_d       = mat_result >> ELEM_W;
          cnt_d       = '0;
          state_d     = S_SEND;
        end
`ifdef MMUL_HOST_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          enable_d = 1'b0;
          err_d    = 1'b1;
          state_d  = S_DRAIN;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end

      S_SEND: begin
        if (out_fire) begin
          if (cnt_q == LAST_OUT) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = S_DRAIN;
          end else begin
            out_data_d = res_q[ELEM_W-1:0];
            res_d      = res_q >> ELEM_W;
            cnt_d      = cnt_q + 1'b1;
          end
        end
      end

      // mmul clears done after enable drops; never start a new load before.
      S_DRAIN: begin
        if (!done) begin
          in_ready_d = 1'b1;
          state_d    = S_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = !((state_d == S_LOAD) && (cnt_d == '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      res_q       <= '0;
`ifdef MMUL_HOST_TIMEOUT_EN
      err_q       <= 1'b0;
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      res_q       <= res_d;
`ifdef MMUL_HOST_TIMEOUT_EN
      err_q       <= err_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;
  assign enable    = enable_q;
  assign busy      = busy_q;

`ifdef MMUL_HOST_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mmul_host.sv
// tb_mmul_host: directed bench for mmul_host with a behavioural mmul stub.
// The stub raises done stub_n cycles after enable rises, holds it for
// stub_hold cycles after enable falls, and always returns
// 72'h090807060504030201 (result element k = k+1).
module tb_mmul_host;

  localparam int ELEM_W = 8;
  localparam int DIM    = 3;
  localparam int MAT_W  = 72;
  localparam int NE     = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ELEM_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ELEM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [MAT_W-1:0]  mat_a;
  logic [MAT_W-1:0]  mat_b;
  logic              enable;
  logic [MAT_W-1:0]  mat_result;
  logic              done;
  logic              busy;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_first = 0;
  int t_last = 0;
  logic err_first = 1'b1;
  logic [7:0] got [NE];

  logic [7:0] va [18] = '{8'd2, 8'd8, 8'd3, 8'd5, 8'd0, 8'd1, 8'd3, 8'd2, 8'd1,
                          8'd8, 8'd0, 8'd2, 8'd1, 8'd6, 8'd5, 8'd3, 8'd0, 8'd0};

  localparam logic [MAT_W-1:0] EXP_A = 72'h010203010005030802;
  localparam logic [MAT_W-1:0] EXP_B = 72'h000003050601020008;

  mmul_host #(
    .ELEM_W(ELEM_W),
    .DIM(DIM),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mat_a(mat_a),
    .mat_b(mat_b),
    .enable(enable),
    .mat_result(mat_result),
    .done(done),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // mmul stub
  int stub_n = 3;
  int stub_hold = 0;
  bit stub_never = 1'b0;
  int s_cnt;
  int h_cnt;

  assign mat_result = 72'h090807060504030201;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      done  <= 1'b0;
      s_cnt <= 0;
      h_cnt <= 0;
    end else if (enable && !done) begin
      if (!stub_never) begin
        if (s_cnt + 1 >= stub_n) begin
          done  <= 1'b1;
          s_cnt <= 0;
        end else begin
          s_cnt <= s_cnt + 1;
        end
      end
    end else if (!enable && done) begin
      if (h_cnt >= stub_hold) begin
        done  <= 1'b0;
        h_cnt <= 0;
      end else begin
        h_cnt <= h_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [MAT_W-1:0] obs,
                     input logic [MAT_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Stream the first nbytes operand bytes; optional input gaps.
  task automatic load(input int nbytes, input bit gaps, input bit check_en);
    int i = 0;
    int guard = 0;
    bit acc;
    while (i < nbytes && guard < 200) begin
      guard++;
      if (gaps && (guard % 3 == 0)) begin
        in_valid = 1'b0;
        tick();
        continue;
      end
      in_valid = 1'b1;
      in_data  = va[i];
      acc = in_ready;
      if (acc && i == 17 && check_en) chk("en_before_last", MAT_W'(enable), '0);
      tick();
      if (acc) begin
        i++;
        if (i == 1) err_first = err;
      end
    end
    in_valid = 1'b0;
    if (i < nbytes) chk("load_bound", MAT_W'(i), MAT_W'(nbytes));
    if (nbytes == 18 && check_en) chk("en_on_last", MAT_W'(enable), 72'd1);
  endtask

  // Collect nbytes result bytes; stall out_ready for stall_len cycles
  // while byte index stall_at is presented.
  task automatic recv(input int nbytes, input int stall_at, input int stall_len,
                      output int ngot);
    int k = 0;
    int guard = 0;
    int st = 0;
    while (k < nbytes && guard < 300) begin
      guard++;
      if (k == stall_at && st < stall_len) begin
        out_ready = 1'b0;
        st++;
        chk("bp_valid", MAT_W'(out_valid), 72'd1);
        chk("bp_data", MAT_W'(out_data), MAT_W'(stall_at + 1));
        tick();
        continue;
      end
      out_ready = 1'b1;
      if (out_valid) begin
        got[k] = out_data;
        chk("en_low_send", MAT_W'(enable), '0);
        if (k == 0) t_first = cyc;
        t_last = cyc;
        k++;
      end
      tick();
    end
    out_ready = 1'b0;
    ngot = k;
  endtask

  task automatic recv_all(input string tag, input int stall_at, input int stall_len);
    int n;
    recv(NE, stall_at, stall_len, n);
    chk({tag, "_count"}, MAT_W'(n), MAT_W'(NE));
    for (int k = 0; k < NE; k++) begin
      if (k < n) chk({tag, "_byte"}, MAT_W'(got[k]), MAT_W'(k + 1));
    end
    chk({tag, "_vld_end"}, MAT_W'(out_valid), '0);
  endtask

  task automatic wait_ready(input string tag);
    int g = 0;
    while (!in_ready && g < 60) begin
      tick();
      g++;
    end
    chk(tag, MAT_W'(in_ready), 72'd1);
  endtask

  task automatic release_rst();
    reset = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    int g;
    // 1. reset values
    repeat (10) tick();
    chk("rst_in_ready", MAT_W'(in_ready), '0);
    chk("rst_out_valid", MAT_W'(out_valid), '0);
    chk("rst_out_data", MAT_W'(out_data), '0);
    chk("rst_mat_a", mat_a, '0);
    chk("rst_mat_b", mat_b, '0);
    chk("rst_enable", MAT_W'(enable), '0);
    chk("rst_busy", MAT_W'(busy), '0);
    chk("rst_err", MAT_W'(err), '0);
    reset = 1'b1;
    tick();
    chk("rdy_edge1", MAT_W'(in_ready), '0);
    tick();
    chk("rdy_edge2", MAT_W'(in_ready), 72'd1);
    chk("busy_load0", MAT_W'(busy), '0);

    // 2. basic transaction
    load(18, 1'b0, 1'b1);
    chk("mat_a", mat_a, EXP_A);
    chk("mat_b", mat_b, EXP_B);
    chk("busy_run", MAT_W'(busy), 72'd1);
    chk("rdy_run", MAT_W'(in_ready), '0);
    recv_all("basic", -1, 0);
    chk("send_spacing", MAT_W'(t_last - t_first), MAT_W'(NE - 1));
    chk("mat_a_frozen", mat_a, EXP_A);
    wait_ready("reload_basic");

    // 3. backpressure with input gaps
    load(18, 1'b1, 1'b1);
    chk("mat_a_gaps", mat_a, EXP_A);
    chk("mat_b_gaps", mat_b, EXP_B);
    recv_all("bp", 3, 5);
    wait_ready("reload_bp");

    // 4. done stuck high after enable falls
    stub_hold = 20;
    load(18, 1'b0, 1'b1);
    recv_all("stuck", -1, 0);
    g = 0;
    while (done && g < 100) begin
      chk("drain_rdy", MAT_W'(in_ready), '0);
      tick();
      g++;
    end
    chk("drain_done_fell", MAT_W'(g < 100), 72'd1);
    chk("drain_edge_fall", MAT_W'(in_ready), '0);
    tick();
    chk("drain_exit", MAT_W'(in_ready), 72'd1);
    chk("drain_exit_busy", MAT_W'(busy), '0);
    stub_hold = 0;

    // 5. reset mid-operation
    load(10, 1'b0, 1'b0);
    chk("mid_rdy_pre", MAT_W'(in_ready), 72'd1);
    reset = 1'b0;
    #1;
    chk("mid_rdy_rst", MAT_W'(in_ready), '0);
    chk("mid_mat_a_rst", mat_a, '0);
    release_rst();
    load(18, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    chk("run_en_rst", MAT_W'(enable), '0);
    release_rst();
    load(18, 1'b0, 1'b1);
    begin
      int n;
      recv(4, -1, 0, n);
      chk("part_count", MAT_W'(n), 72'd4);
    end
    chk("part_vld_pre", MAT_W'(out_valid), 72'd1);
    reset = 1'b0;
    #1;
    chk("part_vld_rst", MAT_W'(out_valid), '0);
    chk("part_en_rst", MAT_W'(enable), '0);
    chk("part_rdy_rst", MAT_W'(in_ready), '0);
    release_rst();
    chk("post_rst_rdy", MAT_W'(in_ready), 72'd1);
    load(18, 1'b0, 1'b1);
    recv_all("post_rst", -1, 0);
    wait_ready("reload_post");
    chk("err_default", MAT_W'(err), '0);

`ifdef MMUL_HOST_TIMEOUT_EN
    // 6. watchdog
    stub_never = 1'b1;
    load(18, 1'b0, 1'b1);
    g = 0;
    while (enable && g < 100) begin
      chk("tmo_no_vld", MAT_W'(out_valid), '0);
      tick();
      g++;
    end
    chk("tmo_cycles", MAT_W'(g), 72'd16);
    chk("tmo_err", MAT_W'(err), 72'd1);
    chk("tmo_vld", MAT_W'(out_valid), '0);
    wait_ready("tmo_reload");
    chk("tmo_err_held", MAT_W'(err), 72'd1);
    stub_never = 1'b0;
    load(18, 1'b0, 1'b1);
    chk("tmo_err_clear", MAT_W'(err_first), '0);
    recv_all("tmo_after", -1, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
